// File: rtl/gpp_noc_interface.sv
// gpp_noc_interface
// Network interface between one GPP core and the photonic router.
//   Transmit side: the GPP pushes {dest, data} words into a TX FIFO. The FSM
//   picks a free wavelength channel round-robin starting at ch_ptr. It then
//   holds rtr_req until rtr_ack arrives. If no ack comes within TIMEOUT
//   cycles it backs off for BACKOFF cycles and retries the same head word.
//   Receive side: the router pushes {src, data} words into an RX FIFO. The
//   GPP drains it through a first-word-fall-through read port.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   send_valid/dest/data, send_ready  GPP -> TX FIFO
//   rtr_req/dest/channel/data, rtr_ack, channel_free  handshake toward router
//   rx_valid/src/data, rx_ready       router -> RX FIFO
//   recv_valid/src/data, recv_ready   RX FIFO -> GPP
//   retry_count                       saturating count of request timeouts
module gpp_noc_interface #(
  parameter int DATA_WIDTH    = 16,
  parameter int NODE_ID_WIDTH = 3,
  parameter int NUM_CHANNELS  = 4,
  parameter int TX_DEPTH      = 4,
  parameter int RX_DEPTH      = 4,
  parameter int TIMEOUT       = 15,
  parameter int BACKOFF       = 4,
  localparam int CH_W         = $clog2(NUM_CHANNELS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     send_valid,
  input  logic [NODE_ID_WIDTH-1:0] send_dest,
  input  logic [DATA_WIDTH-1:0]    send_data,
  output logic                     send_ready,
  output logic                     rtr_req,
  output logic [NODE_ID_WIDTH-1:0] rtr_dest,
  output logic [CH_W-1:0]          rtr_channel,
  output logic [DATA_WIDTH-1:0]    rtr_data,
  input  logic                     rtr_ack,
  input  logic [NUM_CHANNELS-1:0]  channel_free,
  input  logic                     rx_valid,
  input  logic [NODE_ID_WIDTH-1:0] rx_src,
  input  logic [DATA_WIDTH-1:0]    rx_data,
  output logic                     rx_ready,
  output logic                     recv_valid,
  output logic [NODE_ID_WIDTH-1:0] recv_src,
  output logic [DATA_WIDTH-1:0]    recv_data,
  input  logic                     recv_ready,
  output logic [7:0]               retry_count
);

  localparam int TX_AW  = $clog2(TX_DEPTH);
  localparam int RX_AW  = $clog2(RX_DEPTH);
  localparam int WORD_W = NODE_ID_WIDTH + DATA_WIDTH;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int BO_W   = $clog2(BACKOFF + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_BACKOFF} state_t;

  // ---------------------------------------------------------------- TX FIFO
  // Pointers carry one extra wrap bit so that full and empty can be told apart.
  logic [WORD_W-1:0] tx_mem [TX_DEPTH];
  logic [TX_AW:0]    tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic              tx_empty, tx_full, tx_push, tx_pop;
  logic [WORD_W-1:0] tx_head;

  assign tx_empty   = (tx_wr_ptr_q == tx_rd_ptr_q);
  assign tx_full    = (tx_wr_ptr_q[TX_AW] != tx_rd_ptr_q[TX_AW]) &&
                      (tx_wr_ptr_q[TX_AW-1:0] == tx_rd_ptr_q[TX_AW-1:0]);
  // A full FIFO refuses the push even when it pops in the same cycle.
  // The ready flag therefore depends only on registered pointers.
  assign send_ready = !tx_full;
  assign tx_push    = send_valid && !tx_full;
  assign tx_head    = tx_mem[tx_rd_ptr_q[TX_AW-1:0]];

  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q + (TX_AW+1)'(tx_push);
    tx_rd_ptr_d = tx_rd_ptr_q + (TX_AW+1)'(tx_pop);
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_q[TX_AW-1:0]] <= {send_dest, send_data};
  end

  // --------------------------------------------------------- channel search
  // Candidate gi is channel (ch_ptr + gi) mod NUM_CHANNELS. The lowest gi
  // whose channel is free wins, which gives a search upward with wrap.
  logic [CH_W-1:0]                   ch_ptr_q, ch_ptr_d;
  logic [NUM_CHANNELS-1:0][CH_W:0]   cand_sum;
  logic [NUM_CHANNELS-1:0][CH_W-1:0] cand_idx;
  logic [NUM_CHANNELS-1:0]           cand_free;
  logic                              free_found;
  logic [CH_W-1:0]                   free_idx;

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_cand
    assign cand_sum[gi]  = {1'b0, ch_ptr_q} + (CH_W+1)'(gi);
    assign cand_idx[gi]  = CH_W'((cand_sum[gi] >= (CH_W+1)'(NUM_CHANNELS)) ?
                                 cand_sum[gi] - (CH_W+1)'(NUM_CHANNELS) :
                                 cand_sum[gi]);
    assign cand_free[gi] = channel_free[cand_idx[gi]];
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    // Walk downward so that the last assignment is the lowest free candidate.
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (cand_free[i]) begin
        free_found = 1'b1;
        free_idx   = cand_idx[i];
      end
    end
  end

  // ----------------------------------------------------------------- TX FSM
  state_t                   state_q, state_d;
  logic [WAIT_W-1:0]        wait_cnt_q, wait_cnt_d;
  logic [BO_W-1:0]          backoff_cnt_q, backoff_cnt_d;
  logic [7:0]               retry_q, retry_d;
  logic [CH_W-1:0]          rtr_channel_q, rtr_channel_d;
  logic [NODE_ID_WIDTH-1:0] rtr_dest_q, rtr_dest_d;
  logic [DATA_WIDTH-1:0]    rtr_data_q, rtr_data_d;

  always_comb begin
    state_d       = state_q;
    ch_ptr_d      = ch_ptr_q;
    wait_cnt_d    = wait_cnt_q;
    backoff_cnt_d = backoff_cnt_q;
    retry_d       = retry_q;
    rtr_channel_d = rtr_channel_q;
    rtr_dest_d    = rtr_dest_q;
    rtr_data_d    = rtr_data_q;
    tx_pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!tx_empty && free_found) begin
          // Latch the head word and channel so they stay stable during REQ.
          rtr_channel_d = free_idx;
          rtr_dest_d    = tx_head[WORD_W-1:DATA_WIDTH];
          rtr_data_d    = tx_head[DATA_WIDTH-1:0];
          wait_cnt_d    = '0;
          state_d       = ST_REQ;
        end
      end
      ST_REQ: begin
        // An ack on the timeout edge takes priority and counts as success.
        if (rtr_ack) begin
          tx_pop   = 1'b1;
          ch_ptr_d = (rtr_channel_q == CH_W'(NUM_CHANNELS - 1)) ? '0 :
                     rtr_channel_q + CH_W'(1);
          state_d  = ST_IDLE;
        end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
          backoff_cnt_d = '0;
          if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
          state_d       = ST_BACKOFF;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_BACKOFF: begin
        if (backoff_cnt_q == BO_W'(BACKOFF - 1)) state_d = ST_IDLE;
        else backoff_cnt_d = backoff_cnt_q + BO_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ch_ptr_q      <= '0;
      wait_cnt_q    <= '0;
      backoff_cnt_q <= '0;
      retry_q       <= '0;
      rtr_channel_q <= '0;
      rtr_dest_q    <= '0;
      rtr_data_q    <= '0;
      tx_wr_ptr_q   <= '0;
      tx_rd_ptr_q   <= '0;
    end else begin
      state_q       <= state_d;
      ch_ptr_q      <= ch_ptr_d;
      wait_cnt_q    <= wait_cnt_d;
      backoff_cnt_q <= backoff_cnt_d;
      retry_q       <= retry_d;
      rtr_channel_q <= rtr_channel_d;
      rtr_dest_q    <= rtr_dest_d;
      rtr_data_q    <= rtr_data_d;
      tx_wr_ptr_q   <= tx_wr_ptr_d;
      tx_rd_ptr_q   <= tx_rd_ptr_d;
    end
  end

  // rtr_req is decoded from the state register, so reset drops it at once.
  assign rtr_req     = (state_q == ST_REQ);
  assign rtr_dest    = rtr_dest_q;
  assign rtr_channel = rtr_channel_q;
  assign rtr_data    = rtr_data_q;
  assign retry_count = retry_q;

  // ---------------------------------------------------------------- RX FIFO
  logic [WORD_W-1:0] rx_mem [RX_DEPTH];
  logic [RX_AW:0]    rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic              rx_empty, rx_full, rx_push, rx_pop;
  logic [WORD_W-1:0] rx_head;

  assign rx_empty   = (rx_wr_ptr_q == rx_rd_ptr_q);
  assign rx_full    = (rx_wr_ptr_q[RX_AW] != rx_rd_ptr_q[RX_AW]) &&
                      (rx_wr_ptr_q[RX_AW-1:0] == rx_rd_ptr_q[RX_AW-1:0]);
  assign rx_ready   = !rx_full;
  assign rx_push    = rx_valid && !rx_full;
  assign rx_pop     = recv_ready && !rx_empty;
  // First-word-fall-through: the head entry is presented straight from storage.
  assign rx_head    = rx_mem[rx_rd_ptr_q[RX_AW-1:0]];
  assign recv_valid = !rx_empty;
  assign recv_src   = rx_head[WORD_W-1:DATA_WIDTH];
  assign recv_data  = rx_head[DATA_WIDTH-1:0];

  always_comb begin
    rx_wr_ptr_d = rx_wr_ptr_q + (RX_AW+1)'(rx_push);
    rx_rd_ptr_d = rx_rd_ptr_q + (RX_AW+1)'(rx_pop);
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr_q[RX_AW-1:0]] <= {rx_src, rx_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
    end else begin
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
    end
  end

endmodule

// File: tb/tb_gpp_noc_interface.sv
// tb_gpp_noc_interface
// Directed bench for gpp_noc_interface with default parameters.
// Each scenario task drives its stimulus and compares the outputs against
// hand-computed values.
module tb_gpp_noc_interface;

  logic        clk = 1'b0;
  logic        rst;
  logic        send_valid;
  logic [2:0]  send_dest;
  logic [15:0] send_data;
  logic        send_ready;
  logic        rtr_req;
  logic [2:0]  rtr_dest;
  logic [1:0]  rtr_channel;
  logic [15:0] rtr_data;
  logic        rtr_ack;
  logic [3:0]  channel_free;
  logic        rx_valid;
  logic [2:0]  rx_src;
  logic [15:0] rx_data;
  logic        rx_ready;
  logic        recv_valid;
  logic [2:0]  recv_src;
  logic [15:0] recv_data;
  logic        recv_ready;
  logic [7:0]  retry_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpp_noc_interface dut (
    .clk(clk), .rst(rst),
    .send_valid(send_valid), .send_dest(send_dest), .send_data(send_data),
    .send_ready(send_ready),
    .rtr_req(rtr_req), .rtr_dest(rtr_dest), .rtr_channel(rtr_channel),
    .rtr_data(rtr_data), .rtr_ack(rtr_ack), .channel_free(channel_free),
    .rx_valid(rx_valid), .rx_src(rx_src), .rx_data(rx_data), .rx_ready(rx_ready),
    .recv_valid(recv_valid), .recv_src(recv_src), .recv_data(recv_data),
    .recv_ready(recv_ready), .retry_count(retry_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    send_valid = 0; send_dest = 0; send_data = 0; rtr_ack = 0;
    channel_free = 4'b0000; rx_valid = 0; rx_src = 0; rx_data = 0; recv_ready = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  // Bounded wait for rtr_req; ok=0 means the budget expired.
  task automatic wait_req(output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (rtr_req) begin
        ok = 1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 0;
    #1;
    rst = 1;
    #2;
    checks++; if (rtr_req !== 1'b0) begin errors++; $display("FAIL reset_rtr_req got %b exp 0", rtr_req); end
    checks++; if (rtr_dest !== 3'd0) begin errors++; $display("FAIL reset_rtr_dest got %0d exp 0", rtr_dest); end
    checks++; if (rtr_channel !== 2'd0) begin errors++; $display("FAIL reset_rtr_channel got %0d exp 0", rtr_channel); end
    checks++; if (rtr_data !== 16'h0) begin errors++; $display("FAIL reset_rtr_data got %h exp 0000", rtr_data); end
    checks++; if (recv_valid !== 1'b0) begin errors++; $display("FAIL reset_recv_valid got %b exp 0", recv_valid); end
    checks++; if (retry_count !== 8'd0) begin errors++; $display("FAIL reset_retry got %0d exp 0", retry_count); end
    checks++; if (send_ready !== 1'b1) begin errors++; $display("FAIL reset_send_ready got %b exp 1", send_ready); end
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready got %b exp 1", rx_ready); end
    tick();
    rst = 0;
    $display("test_reset done");
  endtask

  task automatic test_single_send();
    bit ok;
    do_reset();
    channel_free = 4'b1111;
    send_valid = 1; send_dest = 3'd3; send_data = 16'hA5A5;
    tick();
    send_valid = 0;
    checks++; if (rtr_req !== 1'b0) begin errors++; $display("FAIL single_req_early got %b exp 0", rtr_req); end
    tick();
    checks++; if (rtr_req !== 1'b1) begin errors++; $display("FAIL single_req_rise got %b exp 1", rtr_req); end
    checks++; if (rtr_channel !== 2'd0) begin errors++; $display("FAIL single_channel got %0d exp 0", rtr_channel); end
    checks++; if (rtr_dest !== 3'd3) begin errors++; $display("FAIL single_dest got %0d exp 3", rtr_dest); end
    checks++; if (rtr_data !== 16'hA5A5) begin errors++; $display("FAIL single_data got %h exp a5a5", rtr_data); end
    rtr_ack = 1;
    tick();
    rtr_ack = 0;
    checks++; if (rtr_req !== 1'b0) begin errors++; $display("FAIL single_req_drop got %b exp 0", rtr_req); end
    checks++; if (send_ready !== 1'b1) begin errors++; $display("FAIL single_send_ready got %b exp 1", send_ready); end
    // ch_ptr should now be 1, so the next word goes out on channel 1.
    send_valid = 1; send_dest = 3'd1; send_data = 16'h0001;
    tick();
    send_valid = 0;
    wait_req(ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_next_timeout got no req exp req"); end
    checks++; if (rtr_channel !== 2'd1) begin errors++; $display("FAIL single_ch_ptr got %0d exp 1", rtr_channel); end
    rtr_ack = 1;
    tick();
    rtr_ack = 0;
    $display("test_single_send done");
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [1:0] exp_ch [3] = '{2'd1, 2'd3, 2'd1};
    do_reset();
    channel_free = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      send_valid = 1; send_dest = 3'(i + 2); send_data = 16'hB000 + 16'(i);
      tick();
    end
    send_valid = 0;
    for (int i = 0; i < 3; i++) begin
      wait_req(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rr_timeout word %0d got no req exp req", i); end
      checks++; if (rtr_channel !== exp_ch[i]) begin errors++; $display("FAIL rr_channel word %0d got %0d exp %0d", i, rtr_channel, exp_ch[i]); end
      checks++; if (rtr_data !== 16'hB000 + 16'(i)) begin errors++; $display("FAIL rr_data word %0d got %h exp %h", i, rtr_data, 16'hB000 + 16'(i)); end
      rtr_ack = 1;
      tick();
      rtr_ack = 0;
      checks++; if (rtr_req !== 1'b0) begin errors++; $display("FAIL rr_idle_gap word %0d got %b exp 0", i, rtr_req); end
      if (i < 2) begin
        tick();
        checks++; if (rtr_req !== 1'b1) begin errors++; $display("FAIL rr_back_to_back word %0d got %b exp 1", i, rtr_req); end
      end
    end
    $display("test_round_robin done");
  endtask

  task automatic test_timeout();
    bit ok;
    int n_hi;
    int n_lo;
    do_reset();
    channel_free = 4'b1111;
    send_valid = 1; send_dest = 3'd5; send_data = 16'h1234;
    tick();
    send_valid = 0;
    wait_req(ok);
    checks++; if (!ok) begin errors++; $display("FAIL to_first_req got no req exp req"); end
    n_hi = 0;
    while (rtr_req && n_hi < 40) begin n_hi++; tick(); end
    n_lo = 0;
    while (!rtr_req && n_lo < 40) begin n_lo++; tick(); end
    checks++; if (n_hi != 15) begin errors++; $display("FAIL to_req_high got %0d cycles exp 15", n_hi); end
    checks++; if (n_lo != 5) begin errors++; $display("FAIL to_req_low got %0d cycles exp 5", n_lo); end
    checks++; if (retry_count !== 8'd1) begin errors++; $display("FAIL to_retry got %0d exp 1", retry_count); end
    checks++; if (rtr_dest !== 3'd5 || rtr_data !== 16'h1234) begin errors++; $display("FAIL to_head got %0d/%h exp 5/1234", rtr_dest, rtr_data); end
    checks++; if (rtr_channel !== 2'd0) begin errors++; $display("FAIL to_channel got %0d exp 0", rtr_channel); end
    rtr_ack = 1;
    tick();
    rtr_ack = 0;
    checks++; if (retry_count !== 8'd1) begin errors++; $display("FAIL to_retry_hold got %0d exp 1", retry_count); end
    $display("test_timeout done");
  endtask

  task automatic test_ack_on_timeout();
    bit ok;
    do_reset();
    channel_free = 4'b1111;
    send_valid = 1; send_dest = 3'd2; send_data = 16'h4242;
    tick();
    send_valid = 0;
    wait_req(ok);
    checks++; if (!ok) begin errors++; $display("FAIL aot_req got no req exp req"); end
    for (int i = 0; i < 14; i++) tick();
    checks++; if (rtr_req !== 1'b1) begin errors++; $display("FAIL aot_req_15th got %b exp 1", rtr_req); end
    rtr_ack = 1;
    tick();
    rtr_ack = 0;
    checks++; if (retry_count !== 8'd0) begin errors++; $display("FAIL aot_retry got %0d exp 0", retry_count); end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (rtr_req !== 1'b0) begin errors++; $display("FAIL aot_no_rereq got %b exp 0", rtr_req); end
    $display("test_ack_on_timeout done");
  endtask

  task automatic test_tx_full();
    bit ok;
    do_reset();
    channel_free = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      send_valid = 1; send_dest = 3'(i); send_data = 16'hC000 + 16'(i);
      tick();
    end
    checks++; if (send_ready !== 1'b0) begin errors++; $display("FAIL full_send_ready got %b exp 0", send_ready); end
    checks++; if (rtr_req !== 1'b1 || rtr_data !== 16'hC000) begin errors++; $display("FAIL full_head got %b/%h exp 1/c000", rtr_req, rtr_data); end
    send_dest = 3'd7; send_data = 16'hC0FF; rtr_ack = 1;
    tick();
    send_valid = 0; rtr_ack = 0;
    checks++; if (send_ready !== 1'b1) begin errors++; $display("FAIL full_after_pop got %b exp 1", send_ready); end
    for (int i = 1; i < 4; i++) begin
      wait_req(ok);
      checks++; if (!ok) begin errors++; $display("FAIL full_drain_timeout word %0d got no req exp req", i); end
      checks++; if (rtr_data !== 16'hC000 + 16'(i) || rtr_dest !== 3'(i)) begin errors++; $display("FAIL full_order word %0d got %0d/%h exp %0d/%h", i, rtr_dest, rtr_data, i, 16'hC000 + 16'(i)); end
      rtr_ack = 1;
      tick();
      rtr_ack = 0;
    end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (rtr_req !== 1'b0) begin errors++; $display("FAIL full_refused_word got req %b exp 0", rtr_req); end
    $display("test_tx_full done");
  endtask

  task automatic test_rx();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1; rx_src = 3'(i + 1); rx_data = 16'hD000 + 16'(i);
      tick();
      if (i == 0) begin
        checks++; if (recv_valid !== 1'b1 || recv_data !== 16'hD000) begin errors++; $display("FAIL rx_fwft got %b/%h exp 1/d000", recv_valid, recv_data); end
      end
    end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_full got %b exp 0", rx_ready); end
    rx_src = 3'd7; rx_data = 16'hD0FF; recv_ready = 1;
    tick();
    rx_valid = 0; recv_ready = 0;
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rx_after_pop got %b exp 1", rx_ready); end
    for (int i = 1; i < 4; i++) begin
      checks++; if (recv_valid !== 1'b1 || recv_src !== 3'(i + 1) || recv_data !== 16'hD000 + 16'(i)) begin
        errors++; $display("FAIL rx_order word %0d got %b/%0d/%h exp 1/%0d/%h", i, recv_valid, recv_src, recv_data, i + 1, 16'hD000 + 16'(i));
      end
      recv_ready = 1;
      tick();
      recv_ready = 0;
    end
    checks++; if (recv_valid !== 1'b0) begin errors++; $display("FAIL rx_empty got %b exp 0", recv_valid); end
    rx_valid = 1; rx_src = 3'd2; rx_data = 16'hE000;
    tick();
    rx_src = 3'd3; rx_data = 16'hE001; recv_ready = 1;
    tick();
    rx_valid = 0; recv_ready = 0;
    checks++; if (recv_valid !== 1'b1 || recv_src !== 3'd3 || recv_data !== 16'hE001) begin errors++; $display("FAIL rx_concurrent got %b/%0d/%h exp 1/3/e001", recv_valid, recv_src, recv_data); end
    recv_ready = 1;
    tick();
    recv_ready = 0;
    checks++; if (recv_valid !== 1'b0) begin errors++; $display("FAIL rx_final_empty got %b exp 0", recv_valid); end
    $display("test_rx done");
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    do_reset();
    channel_free = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      send_valid = 1; send_dest = 3'(i); send_data = 16'hF000 + 16'(i);
      tick();
    end
    send_valid = 0;
    wait_req(ok);
    n = 0;
    while (rtr_req && n < 40) begin n++; tick(); end
    checks++; if (retry_count !== 8'd1) begin errors++; $display("FAIL mid_retry_pre got %0d exp 1", retry_count); end
    rx_valid = 1; rx_src = 3'd4; rx_data = 16'h7777;
    tick();
    rx_valid = 0;
    wait_req(ok);
    checks++; if (!ok || recv_valid !== 1'b1) begin errors++; $display("FAIL mid_setup got req %b recv_valid %b exp 1/1", rtr_req, recv_valid); end
    #2;
    rst = 1;
    #1;
    checks++; if (rtr_req !== 1'b0) begin errors++; $display("FAIL mid_async_drop got %b exp 0", rtr_req); end
    tick();
    rst = 0;
    checks++; if (recv_valid !== 1'b0) begin errors++; $display("FAIL mid_recv_valid got %b exp 0", recv_valid); end
    checks++; if (send_ready !== 1'b1) begin errors++; $display("FAIL mid_send_ready got %b exp 1", send_ready); end
    checks++; if (retry_count !== 8'd0) begin errors++; $display("FAIL mid_retry got %0d exp 0", retry_count); end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (rtr_req !== 1'b0) begin errors++; $display("FAIL mid_discarded got %b exp 0", rtr_req); end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_single_send();
    test_round_robin();
    test_timeout();
    test_ack_on_timeout();
    test_tx_full();
    test_rx();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpp_noc_interface.md
# gpp_noc_interface

Parametrised network interface between one general-purpose processor (GPP) core and the photonic router. It buffers outbound words in a transmit FIFO and selects a free wavelength channel round-robin. It holds a request/acknowledge handshake toward the router, with timeout and backoff. Inbound words go into a receive FIFO that the GPP drains. It replaces the raw router-enable decode of the single-core GPP and is instantiated once per core in multi-core builds.

## Interface
- DATA_WIDTH, 16, payload width (matches GPP data word)
- NODE_ID_WIDTH, 3, width of source/destination node ID
- NUM_CHANNELS, 4, wavelength channels (>=2); CH_W = $clog2(NUM_CHANNELS)
- TX_DEPTH, 4, transmit FIFO depth (power of two, >=2)
- RX_DEPTH, 4, receive FIFO depth (power of two, >=2)
- TIMEOUT, 15, max cycles a request is held without ack (>=1)
- BACKOFF, 4, idle cycles after a timeout (>=1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- send_valid  in  1  GPP offers a word
- send_dest  in  NODE_ID_WIDTH  destination node
- send_data  in  DATA_WIDTH  payload
- send_ready  out  1  TX FIFO not full
- rtr_req  out  1  request to router
- rtr_dest  out  NODE_ID_WIDTH  destination of head word
- rtr_channel  out  CH_W  selected wavelength channel
- rtr_data  out  DATA_WIDTH  head-word payload
- rtr_ack  in  1  router accepted the word
- channel_free  in  NUM_CHANNELS  per-channel free status from router
- rx_valid  in  1  router delivers a word
- rx_src  in  NODE_ID_WIDTH  source node
- rx_data  in  DATA_WIDTH  payload
- rx_ready  out  1  RX FIFO not full
- recv_valid  out  1  RX FIFO not empty
- recv_src  out  NODE_ID_WIDTH  head source
- recv_data  out  DATA_WIDTH  head payload
- recv_ready  in  1  GPP consumes head word
- retry_count  out  8  saturating timeout count

## Operation
- TX FIFO stores {dest, data}. Push on send_valid & send_ready. send_ready = !tx_full and is derived from registered state only. A full FIFO rejects a push even in a cycle where it pops.
- TX FSM states are IDLE, REQ and BACKOFF.
  - IDLE: if the FIFO is non-empty and any channel_free bit is set, search from ch_ptr upward with wrap. Register the first free index into rtr_channel, load rtr_dest/rtr_data from the head, clear wait_cnt, and go to REQ. Otherwise stay in IDLE.
  - REQ: rtr_req=1. rtr_dest, rtr_channel and rtr_data stay stable regardless of channel_free.
    - On rtr_ack: pop the head, set ch_ptr = (rtr_channel+1) mod NUM_CHANNELS, go to IDLE.
    - Else, when wait_cnt reaches TIMEOUT-1 (TIMEOUT sampled edges without ack): go to BACKOFF, increment retry_count (saturates at 255), and do not pop.
    - Else wait_cnt++.
    - Ack on the timeout edge counts as success.
  - BACKOFF: rtr_req=0 for BACKOFF cycles, then go to IDLE. The head word is retried with a fresh channel search.
- RX FIFO stores {src, data}. Push on rx_valid & rx_ready, with rx_ready = !rx_full. Pop on recv_valid & recv_ready.
- RX read is first-word-fall-through: recv_* shows the head combinationally from storage.
- RX push and pop may occur in the same cycle when the FIFO is neither empty nor full. When full, the pop proceeds and the push is refused.
- FIFO pointers wrap modulo depth. An extra occupancy bit or counter distinguishes full from empty.

## Timing
- Reset values:
  - rtr_req=0, rtr_dest=0, rtr_channel=0, rtr_data=0.
  - recv_valid=0, retry_count=0.
  - send_ready=1, rx_ready=1.
  - FSM in IDLE, ch_ptr=0, wait_cnt=0, both FIFOs empty.
- Reset mid-operation discards FIFO contents and drops rtr_req immediately, asynchronously.
- Word pushed at edge N into an empty TX FIFO with a channel free: IDLE sees it at edge N+1, and rtr_req is high after edge N+1. rtr_ack sampled at edge N+1+k pops the word.
- Back-to-back sends: one IDLE cycle between requests, so peak TX throughput is 1 word per 2 cycles.
- Timeout: rtr_req stays high for exactly TIMEOUT cycles, then is low for BACKOFF cycles, then IDLE for 1 cycle. A retry request is therefore seen TIMEOUT+BACKOFF+1 cycles after the first request rose.
- RX: word pushed at edge N gives recv_valid=1 after edge N, in the same cycle the FIFO becomes non-empty. Peak RX throughput is 1 word per cycle.

## Test plan
- Single send: reset, push dest=3 data=0xA5A5 with channel_free=4'b1111, ack one cycle after rtr_req rises -> rtr_channel=0, rtr_dest=3, rtr_data=0xA5A5; after ack ch_ptr=1 and send_ready=1.
- Round-robin and skip: channel_free=4'b1010, send 3 words, ack each immediately -> channels 1, 3, 1.
- Timeout/backoff: TIMEOUT=15, BACKOFF=4, never ack -> rtr_req high exactly 15 cycles, low 4, IDLE 1, then re-requests. retry_count=1 and the head word is unchanged. Ack on the 15th edge -> retry_count stays 0.
- TX full: hold rtr_ack=0, push 4 words -> send_ready=0, and a 5th push is refused while popping. Drain with acks -> words leave in push order.
- RX concurrency: fill RX with 4 words (rx_ready=0), then recv_ready=1 and rx_valid=1 together -> pop accepted, push refused that cycle. Data and src come out in order.
- Reset mid-request: assert rst while rtr_req=1 with 2 words queued -> rtr_req=0 immediately; after release recv_valid=0, send_ready=1, retry_count=0.
